// File: rtl/ctrl_pkg.sv
// ctrl_pkg: FSM states, condition codes and ALU encodings shared by the multicycle controller.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH
    } state_t;

    typedef enum logic [3:0] {
        EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL, NV
    } cond_t;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    function automatic state_t next_state(input state_t s, input logic [1:0] op, input logic [5:0] funct);
        case (s)
            FETCH:              return DECODE;
            DECODE:             return op == 2'b00 ? (funct[5] ? EXECUTEI : EXECUTER) :
                                       op == 2'b01 ? MEMADR :
                                       op == 2'b10 ? BRANCH : FETCH;
            MEMADR:             return funct[0] ? MEMRD : MEMWR;
            MEMRD:              return MEMWB;
            EXECUTER, EXECUTEI: return ALUWB;
            default:            return FETCH;
        endcase
    endfunction

    function automatic logic [1:0] alu_ctrl(input logic [3:0] cmd);
        return cmd == CMD_ADD ? ALU_ADD :
               cmd == CMD_SUB ? ALU_SUB :
               cmd == CMD_AND ? ALU_AND :
               cmd == CMD_ORR ? ALU_ORR :
               cmd == CMD_CMP ? ALU_SUB : ALU_ADD;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_cond.sv
// cond_unit: NZCV flag register, condition evaluation and the per-instruction condition latch.
module cond_unit
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic       nz_we,
    input  logic       cv_we,
    input  logic       latch,
    output logic       cond_ex_q
);

    logic [3:0] flags;
    logic       n, z, c, v, cond_ex;

    assign {n, z, c, v} = flags;

    always_comb begin
        case (cond_t'(cond))
            EQ:      cond_ex = z;
            NE:      cond_ex = ~z;
            CS:      cond_ex = c;
            CC:      cond_ex = ~c;
            MI:      cond_ex = n;
            PL:      cond_ex = ~n;
            VS:      cond_ex = v;
            VC:      cond_ex = ~v;
            HI:      cond_ex = c & ~z;
            LS:      cond_ex = ~c | z;
            GE:      cond_ex = n == v;
            LT:      cond_ex = n != v;
            GT:      cond_ex = ~z & (n == v);
            LE:      cond_ex = z | (n != v);
            AL:      cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flags     <= 4'b0000;
            cond_ex_q <= 1'b0;
        end else begin
            if (nz_we) flags[3:2] <= alu_flags[3:2];
            if (cv_we) flags[1:0] <= alu_flags[1:0];
            if (latch) cond_ex_q <= cond_ex;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle ARM-subset control FSM with conditional write gating.
// Define CTRL_PERF_CNT_EN to add the instr_retired counter output.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [31:12] Instr,
    input  logic [3:0]   ALUFlags,
    output logic         PCWrite,
    output logic         MemWrite,
    output logic         RegWrite,
    output logic         IRWrite,
    output logic         AdrSrc,
    output logic [1:0]   RegSrc,
    output logic [1:0]   ALUSrcA,
    output logic [1:0]   ALUSrcB,
    output logic [1:0]   ResultSrc,
    output logic [1:0]   ImmSrc,
    output logic [1:0]   ALUControl
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0]  instr_retired
`endif
);

    state_t     state, cur;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd;
    logic       irw, nextpc, regw, memw, branch, aluop;
    logic       no_write, cond_ex_q, reg_ok, exec, nz_we, unused_rn;

    assign op        = Instr[27:26];
    assign funct     = Instr[25:20];
    assign cmd       = funct[4:1];
    assign unused_rn = ^Instr[19:16];
    // While in reset the datapath muxes present their FETCH setting.
    assign cur       = reset_n ? state : FETCH;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= state_t'(RESET_STATE);
        else state <= next_state(state, op, funct);
    end

    always_comb begin
        {irw, nextpc, regw, memw, branch, aluop, AdrSrc} = '0;
        {ALUSrcA, ALUSrcB, ResultSrc} = '0;
        case (cur)
            FETCH:    begin irw = 1'b1; nextpc = 1'b1; ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10; end
            DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10; end
            MEMADR:   ALUSrcB = 2'b01;
            MEMRD:    AdrSrc = 1'b1;
            MEMWB:    begin ResultSrc = 2'b01; regw = 1'b1; end
            MEMWR:    begin AdrSrc = 1'b1; memw = 1'b1; end
            EXECUTER: aluop = 1'b1;
            EXECUTEI: begin ALUSrcB = 2'b01; aluop = 1'b1; end
            ALUWB:    regw = 1'b1;
            BRANCH:   begin ALUSrcB = 2'b01; ResultSrc = 2'b10; branch = 1'b1; end
            default:  ;
        endcase
    end

    // CMP is flagged from the held instruction so its ALUWB stays write-free.
    assign no_write   = op == 2'b00 && cmd == CMD_CMP;
    assign reg_ok     = regw & cond_ex_q & ~no_write;
    assign RegWrite   = reset_n & reg_ok;
    assign MemWrite   = reset_n & memw & cond_ex_q;
    assign IRWrite    = reset_n & irw;
    assign PCWrite    = reset_n & (nextpc | (branch & cond_ex_q) | (reg_ok & Instr[15:12] == 4'hF));
    assign ALUControl = aluop ? alu_ctrl(cmd) : ALU_ADD;
    assign ImmSrc     = op;
    assign RegSrc     = {op == 2'b01, op == 2'b10};

    assign exec  = state == EXECUTER || state == EXECUTEI;
    assign nz_we = exec && cond_ex_q && funct[0];

    cond_unit u_cond (
        .clk       (clk),
        .reset_n   (reset_n),
        .cond      (Instr[31:28]),
        .alu_flags (ALUFlags),
        .nz_we     (nz_we),
        .cv_we     (nz_we && (cmd == CMD_ADD || cmd == CMD_SUB || cmd == CMD_CMP)),
        .latch     (state == DECODE),
        .cond_ex_q (cond_ex_q)
    );

`ifdef CTRL_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset_n) instr_retired <= '0;
        else if (state != FETCH && next_state(state, op, funct) == FETCH) instr_retired <= instr_retired + 32'd1;
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed and random instruction streams checked against an instruction-level model.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [19:0] instr = '0;
    logic [3:0]  alu_flags = '0;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] instr_retired;
    logic [31:0] m_ret = '0;
`endif
    int          checks = 0;
    int          errors = 0;
    logic [3:0]  m_flags = '0;
    logic        m_cex = 1'b0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .Instr      (instr),
        .ALUFlags   (alu_flags),
        .PCWrite    (PCWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .RegSrc     (RegSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl)
`ifdef CTRL_PERF_CNT_EN
        ,
        .instr_retired (instr_retired)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ARM rule: pairs of codes share a base test, odd code inverts it; 1111 never executes.
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic base;
        if (c == 4'hF) return 1'b0;
        case (c[3:1])
            3'd0:    base = f[2];
            3'd1:    base = f[1];
            3'd2:    base = f[3];
            3'd3:    base = f[0];
            3'd4:    base = f[1] & ~f[2];
            3'd5:    base = f[3] == f[0];
            3'd6:    base = ~f[2] & (f[3] == f[0]);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    function automatic logic [1:0] alu_of(input logic [3:0] cmd);
        case (cmd)
            4'b0010, 4'b1010: return 2'b01;
            4'b0000:          return 2'b10;
            4'b1100:          return 2'b11;
            default:          return 2'b00;
        endcase
    endfunction

    function automatic logic [19:0] mk(input logic [3:0] c, input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd);
        return {c, op, fn, 4'h0, rd};
    endfunction

    // One clock cycle: check outputs mid-cycle, then cross the next active edge.
    task automatic step(input string ph, input logic [3:0] we, input logic adr, input logic [1:0] alu, input logic [5:0] mux);
        @(negedge clk);
        check({ph, " we"}, {PCWrite, MemWrite, RegWrite, IRWrite}, we);
        check({ph, " adr"}, AdrSrc, adr);
        check({ph, " aluctl"}, ALUControl, alu);
        check({ph, " mux"}, {ALUSrcA, ALUSrcB, ResultSrc}, mux);
        check({ph, " sel"}, {RegSrc, ImmSrc}, {instr[15:14] == 2'b01, instr[15:14] == 2'b10, instr[15:14]});
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [19:0] ins, input logic [3:0] exf);
        logic [1:0] op;
        logic [5:0] fn;
        logic       pf, wb;
        op = ins[15:14];
        fn = ins[13:8];
        pf = ins[3:0] == 4'hF;
        instr = ins;
        alu_flags = 4'($urandom);
        step("fetch", 4'b1001, 1'b0, 2'b00, 6'b011010);
        step("decode", 4'b0000, 1'b0, 2'b00, 6'b011010);
        m_cex = cond_pass(ins[19:16], m_flags);
        case (op)
            2'b10: step("branch", {m_cex, 3'b000}, 1'b0, 2'b00, 6'b000110);
            2'b01: begin
                step("memadr", 4'b0000, 1'b0, 2'b00, 6'b000100);
                if (fn[0]) begin
                    step("memrd", 4'b0000, 1'b1, 2'b00, 6'b000000);
                    step("memwb", {m_cex & pf, 1'b0, m_cex, 1'b0}, 1'b0, 2'b00, 6'b000001);
                end else begin
                    step("memwr", {1'b0, m_cex, 2'b00}, 1'b1, 2'b00, 6'b000000);
                end
            end
            2'b00: begin
                alu_flags = exf;
                step(fn[5] ? "execi" : "execr", 4'b0000, 1'b0, alu_of(fn[4:1]), fn[5] ? 6'b000100 : 6'b000000);
                if (m_cex && fn[0]) begin
                    m_flags[3:2] = exf[3:2];
                    if (fn[4:1] inside {4'b0100, 4'b0010, 4'b1010}) m_flags[1:0] = exf[1:0];
                end
                wb = m_cex && fn[4:1] != 4'b1010;
                alu_flags = 4'($urandom);
                step("aluwb", {wb & pf, 1'b0, wb, 1'b0}, 1'b0, 2'b00, 6'b000000);
            end
            default: ;
        endcase
        check("flags", {28'd0, dut.u_cond.flags}, {28'd0, m_flags});
`ifdef CTRL_PERF_CNT_EN
        m_ret++;
        check("retired", instr_retired, m_ret);
`endif
    endtask

    initial begin
        logic [3:0] cmds [5];
        logic [5:0] fn;
        logic [1:0] op;
        cmds = '{4'b0000, 4'b0010, 4'b0100, 4'b1010, 4'b1100};
        step("reset", 4'b0000, 1'b0, 2'b00, 6'b011010);
        step("reset", 4'b0000, 1'b0, 2'b00, 6'b011010);
        reset_n = 1'b1;
        check("flags after reset", {28'd0, dut.u_cond.flags}, 32'd0);
`ifdef CTRL_PERF_CNT_EN
        check("retired after reset", instr_retired, 32'd0);
`endif
        run_instr(mk(4'hE, 2'b00, 6'b101001, 4'h1), 4'b0110);
        run_instr(mk(4'h0, 2'b10, 6'b000000, 4'h0), 4'b0000);
        run_instr(mk(4'hE, 2'b00, 6'b101001, 4'h1), 4'b0011);
        run_instr(mk(4'h0, 2'b10, 6'b000000, 4'h0), 4'b0000);
        run_instr(mk(4'hE, 2'b00, 6'b010101, 4'h2), 4'b1000);
        run_instr(mk(4'hB, 2'b00, 6'b101000, 4'h3), 4'b0000);
        run_instr(mk(4'hF, 2'b01, 6'b000001, 4'h4), 4'b0000);
        run_instr(mk(4'hE, 2'b01, 6'b000000, 4'h5), 4'b0000);
        run_instr(mk(4'hE, 2'b00, 6'b101000, 4'hF), 4'b0000);
        run_instr(mk(4'hE, 2'b11, 6'b000000, 4'h0), 4'b0000);
        run_instr(mk(4'hE, 2'b11, 6'b000000, 4'h0), 4'b0000);
        run_instr(mk(4'hE, 2'b11, 6'b000000, 4'h0), 4'b0000);
        // Abort a store in MEMWR with reset: no memory write, fresh FETCH afterwards.
        instr = mk(4'hE, 2'b01, 6'b000000, 4'h6);
        step("fetch", 4'b1001, 1'b0, 2'b00, 6'b011010);
        step("decode", 4'b0000, 1'b0, 2'b00, 6'b011010);
        step("memadr", 4'b0000, 1'b0, 2'b00, 6'b000100);
        reset_n = 1'b0;
        step("abort", 4'b0000, 1'b0, 2'b00, 6'b011010);
        reset_n = 1'b1;
        m_flags = '0;
        m_cex = 1'b0;
`ifdef CTRL_PERF_CNT_EN
        m_ret = '0;
`endif
        run_instr(mk(4'hE, 2'b11, 6'b000000, 4'h0), 4'b0000);
        for (int i = 0; i < 300; i++) begin
            op = 2'($urandom);
            fn = 6'($urandom);
            if (op == 2'b00) fn[4:1] = cmds[$urandom_range(0, 4)];
            run_instr(mk(4'($urandom), op, fn, $urandom_range(0, 3) == 0 ? 4'hF : 4'($urandom)), 4'($urandom));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
